// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the 5-stage MIPS pipeline.
//   regbits_t      : register-select field (rs/rt/rd)
//   hazard_state_t : hazard controller sequencer states
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int REGBITS_W = 5;

    typedef logic [REGBITS_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        DRAIN     = 2'd2,
        HALTED    = 2'd3
    } hazard_state_t;

endpackage : cpu_types_pkg

// File: rtl/hazard_controller_if.sv
// -----------------------------------------------------------------------------
// hazard_controller_if
// Bundles the hazard controller signals.
//   modport hc : controller side (pipeline status in, enables/flushes out)
//   modport tb : driver/monitor side (mirror of hc)
// -----------------------------------------------------------------------------
interface hazard_controller_if #(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input logic CLK,
    input logic nRST
);
    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] de_rs;
    logic [REG_W-1:0] de_rt;
    logic             de_uses_rt;
    logic             ex_dREN;
    logic [REG_W-1:0] ex_wsel;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_taken;
    logic             de_halt;
    logic             wb_halt;
    logic             pc_en;
    logic             fd_en;
    logic             de_en;
    logic             em_en;
    logic             mw_en;
    logic             fd_flush;
    logic             de_flush;
    logic             em_flush;
    logic             mw_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;

    modport hc (
        input  CLK, nRST, ihit, dhit, de_rs, de_rt, de_uses_rt, ex_dREN, ex_wsel,
               mem_dREN, mem_dWEN, ex_taken, de_halt, wb_halt,
        output pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, mw_flush, halt, stall_cnt
    );

    modport tb (
        input  CLK, nRST, pc_en, fd_en, de_en, em_en, mw_en,
               fd_flush, de_flush, em_flush, mw_flush, halt, stall_cnt,
        output ihit, dhit, de_rs, de_rt, de_uses_rt, ex_dREN, ex_wsel,
               mem_dREN, mem_dWEN, ex_taken, de_halt, wb_halt
    );

endinterface : hazard_controller_if

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline.
//   Inputs : CLK, nRST (async, active-low), ihit/dhit cache status, decode
//            operands (de_rs, de_rt, de_uses_rt), execute load info
//            (ex_dREN, ex_wsel), memory access (mem_dREN, mem_dWEN),
//            branch resolution (ex_taken), halt markers (de_halt, wb_halt).
//   Outputs: pc_en, per-latch enables (fd/de/em/mw_en) and flushes
//            (fd/de/em/mw_flush, flush dominates enable), sticky halt and a
//            saturating stall-cycle counter stall_cnt.
// Enables/flushes are combinational; state, halt and stall_cnt are registered.
// -----------------------------------------------------------------------------
module hazard_controller
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic [REG_W-1:0] de_rs,
    input  logic [REG_W-1:0] de_rt,
    input  logic             de_uses_rt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             ex_taken,
    input  logic             de_halt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    hazard_state_t    state_q, state_d;
    logic             halt_q, halt_d;
    logic [CNT_W-1:0] cnt_q;

    logic dmem_busy;
    logic lu;
    logic in_drain;

    assign dmem_busy = (mem_dREN | mem_dWEN) & ~dhit;
    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign lu = ex_dREN & (ex_wsel != {REG_W{1'b0}}) &
                ((ex_wsel == de_rs) | (de_uses_rt & (ex_wsel == de_rt)));
    assign in_drain = (state_q == DRAIN);

    // Next-state, halt and enable/flush decode.
    always_comb begin
        state_d  = state_q;
        halt_d   = halt_q;
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_en    = 1'b0;
        em_en    = 1'b0;
        mw_en    = 1'b0;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        mw_flush = 1'b0;

        if (!nRST) begin
            // Reset loads bubbles everywhere, visible immediately.
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
        end else begin
            case (state_q)
                RUN, DMEM_WAIT, DRAIN: begin
                    if ((state_q == DMEM_WAIT) && !dhit) begin
                        // Frozen: ihit ignored, fetch is retried after release.
                        state_d = DMEM_WAIT;
                    end else if ((state_q != DMEM_WAIT) && dmem_busy) begin
                        state_d = in_drain ? DRAIN : DMEM_WAIT;
                    end else begin
                        // Release from DMEM_WAIT behaves as RUN with the memory free.
                        state_d = in_drain ? DRAIN : RUN;
                        if (ex_taken) begin
                            // Wrong-path fetch/decode squashed; beats lu and de_halt.
                            pc_en    = 1'b1;
                            fd_flush = 1'b1;
                            de_flush = 1'b1;
                            em_en    = 1'b1;
                            mw_en    = 1'b1;
                        end else if (lu) begin
                            // One bubble into execute; decode holds.
                            de_flush = 1'b1;
                            em_en    = 1'b1;
                            mw_en    = 1'b1;
                        end else if (de_halt && !in_drain) begin
                            state_d  = DRAIN;
                            fd_flush = 1'b1;
                            de_en    = 1'b1;
                            em_en    = 1'b1;
                            mw_en    = 1'b1;
                        end else begin
                            pc_en    = ihit;
                            fd_en    = ihit;
                            fd_flush = ~ihit;
                            de_en    = 1'b1;
                            em_en    = 1'b1;
                            mw_en    = 1'b1;
                        end
                        // Draining: nothing new enters the pipe.
                        if (in_drain) begin
                            pc_en    = 1'b0;
                            fd_en    = 1'b0;
                            fd_flush = 1'b1;
                        end else begin
                            fd_en    = fd_en & ~fd_flush;
                        end
                    end
                    // The halt instruction retiring ends the drain.
                    if (in_drain && wb_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        halt_d  = halt_q;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                    halt_d  = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    halt_d  = 1'b0;
                end
            endcase
        end
    end

    // State and sticky halt registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Saturating count of cycles with the PC frozen before halting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= {CNT_W{1'b0}};
        end else if ((state_q != HALTED) && !pc_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign halt      = halt_q;
    assign stall_cnt = cnt_q;

endmodule : hazard_controller

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;
    localparam int CNT_W = 32;
    localparam int REG_W = 5;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, de_uses_rt, ex_dREN, mem_dREN, mem_dWEN;
    logic             ex_taken, de_halt, wb_halt;
    logic [REG_W-1:0] de_rs, de_rt, ex_wsel;
    logic             pc_en, fd_en, de_en, em_en, mw_en;
    logic             fd_flush, de_flush, em_flush, mw_flush, halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [4:0]       en_v;
    logic [3:0]       fl_v;

    int checks = 0;
    int errors = 0;

    assign en_v = {pc_en, fd_en, de_en, em_en, mw_en};
    assign fl_v = {fd_flush, de_flush, em_flush, mw_flush};

    always #5 CLK = ~CLK;

    hazard_controller #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .de_rs(de_rs), .de_rt(de_rt), .de_uses_rt(de_uses_rt),
        .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN),
        .ex_taken(ex_taken), .de_halt(de_halt), .wb_halt(wb_halt),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; de_rs = 5'd0; de_rt = 5'd0; de_uses_rt = 1'b0;
        ex_dREN = 1'b0; ex_wsel = 5'd0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_taken = 1'b0; de_halt = 1'b0; wb_halt = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released and inputs idle.
    task automatic do_reset();
        idle();
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        nRST = 1'b0;
        #1;
        checks++; if (fl_v !== 4'b1111) begin errors++; $display("FAIL reset_flush got %b exp %b", fl_v, 4'b1111); end
        checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL reset_en got %b exp %b", en_v, 5'b00000); end
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt got %b exp 0", halt); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", stall_cnt); end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL run_idle_en got %b exp %b", en_v, 5'b11111); end
        checks++; if (fl_v !== 4'b0000) begin errors++; $display("FAIL run_idle_flush got %b exp %b", fl_v, 4'b0000); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_dREN = 1'b1; ex_wsel = 5'd5; de_rs = 5'd5; ihit = 1'b1;
        #1;
        checks++; if (en_v !== 5'b00011) begin errors++; $display("FAIL lu_en got %b exp %b", en_v, 5'b00011); end
        checks++; if (fl_v !== 4'b0100) begin errors++; $display("FAIL lu_flush got %b exp %b", fl_v, 4'b0100); end
        @(negedge CLK);
        ex_dREN = 1'b0;
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_after_en got %b exp %b", en_v, 5'b11111); end
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        // Load into r0 never stalls.
        @(negedge CLK);
        ex_dREN = 1'b1; ex_wsel = 5'd0; de_rs = 5'd0;
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_r0_en got %b exp %b", en_v, 5'b11111); end
        // rt match ignored when rt is not read.
        @(negedge CLK);
        ex_wsel = 5'd7; de_rs = 5'd3; de_rt = 5'd7; de_uses_rt = 1'b0;
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL lu_rt_unused_en got %b exp %b", en_v, 5'b11111); end
        @(negedge CLK);
        de_uses_rt = 1'b1;
        #1;
        checks++; if (en_v !== 5'b00011) begin errors++; $display("FAIL lu_rt_en got %b exp %b", en_v, 5'b00011); end
        @(negedge CLK);
        idle();
        #1;
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_rt_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_branch_lu();
        do_reset();
        ex_taken = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd9; de_rs = 5'd9; de_halt = 1'b1;
        #1;
        checks++; if (en_v !== 5'b10011) begin errors++; $display("FAIL br_en got %b exp %b", en_v, 5'b10011); end
        checks++; if (fl_v !== 4'b1100) begin errors++; $display("FAIL br_flush got %b exp %b", fl_v, 4'b1100); end
        @(negedge CLK);
        idle();
        #1;
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL br_cnt got %0d exp 0", stall_cnt); end
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL br_next_en got %b exp %b", en_v, 5'b11111); end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            mem_dREN = 1'b1; dhit = 1'b0;
            #1;
            checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL dw_en[%0d] got %b exp %b", i, en_v, 5'b00000); end
            checks++; if (fl_v !== 4'b0000) begin errors++; $display("FAIL dw_flush[%0d] got %b exp %b", i, fl_v, 4'b0000); end
            @(negedge CLK);
        end
        dhit = 1'b1;
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL dw_release_en got %b exp %b", en_v, 5'b11111); end
        @(negedge CLK);
        idle();
        #1;
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dw_cnt got %0d exp 3", stall_cnt); end
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL dw_run_en got %b exp %b", en_v, 5'b11111); end
    endtask

    task automatic test_fetch_miss();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ihit = 1'b0;
            #1;
            checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL fm_en[%0d] got %b exp %b", i, en_v, 5'b00111); end
            checks++; if (fl_v !== 4'b1000) begin errors++; $display("FAIL fm_flush[%0d] got %b exp %b", i, fl_v, 4'b1000); end
            @(negedge CLK);
        end
        ihit = 1'b1;
        #1;
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL fm_cnt got %0d exp 2", stall_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        wb_halt = 1'b1;   // outside DRAIN: ignored
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL wb_run_en got %b exp %b", en_v, 5'b11111); end
        @(negedge CLK);
        wb_halt = 1'b0;
        #1;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL wb_run_halt got %b exp 0", halt); end
        de_halt = 1'b1;
        #1;
        checks++; if (en_v !== 5'b00111) begin errors++; $display("FAIL dh_en got %b exp %b", en_v, 5'b00111); end
        checks++; if (fl_v !== 4'b1000) begin errors++; $display("FAIL dh_flush got %b exp %b", fl_v, 4'b1000); end
        @(negedge CLK);
        de_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_halt = (i == 2);
            #1;
            checks++; if (fl_v !== 4'b1000) begin errors++; $display("FAIL drain_flush[%0d] got %b exp %b", i, fl_v, 4'b1000); end
            checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL drain_pc[%0d] got %b exp 0", i, pc_en); end
            checks++; if (halt !== 1'b0) begin errors++; $display("FAIL drain_halt[%0d] got %b exp 0", i, halt); end
            @(negedge CLK);
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halted_halt[%0d] got %b exp 1", i, halt); end
            checks++; if (en_v !== 5'b00000) begin errors++; $display("FAIL halted_en[%0d] got %b exp %b", i, en_v, 5'b00000); end
            checks++; if (fl_v !== 4'b0000) begin errors++; $display("FAIL halted_flush[%0d] got %b exp %b", i, fl_v, 4'b0000); end
            @(negedge CLK);
        end
        #1;
        checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL halt_cnt got %0d exp 4", stall_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        mem_dREN = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        checks++; if (halt !== 1'b0) begin errors++; $display("FAIL rmw_halt got %b exp 0", halt); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmw_cnt got %0d exp 0", stall_cnt); end
        checks++; if (fl_v !== 4'b1111) begin errors++; $display("FAIL rmw_flush got %b exp %b", fl_v, 4'b1111); end
        @(negedge CLK);
        nRST = 1'b1;
        idle();
        #1;
        checks++; if (en_v !== 5'b11111) begin errors++; $display("FAIL rmw_run_en got %b exp %b", en_v, 5'b11111); end
        @(negedge CLK);
        #1;
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rmw_run_cnt got %0d exp 0", stall_cnt); end
    endtask

    initial begin
        nRST = 1'b0;
        idle();
        @(negedge CLK);
        test_reset();
        test_load_use();
        test_branch_lu();
        test_dmem_wait();
        test_fetch_miss();
        test_halt();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_controller

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Watches decode operands, execute/memory stage state, cache hit signals, branch resolution and halt.
- Drives the PC enable and per-latch enable/flush for the fetch/decode (fd), decode/execute (de), execute/mem (em) and mem/writeback (mw) latches.
- Owns the halt-drain FSM and a stall-cycle performance counter.

Parameters:
CNT_W, 32, width of stall_cnt (saturating)
REG_W, 5, register-select width

Ports:
CLK  in  1  clock
nRST  in  1  asynchronous active-low reset
ihit  in  1  instruction fetch valid this cycle
dhit  in  1  data access complete this cycle
de_rs  in  REG_W  rs of instruction in decode
de_rt  in  REG_W  rt of instruction in decode
de_uses_rt  in  1  decode instruction reads rt
ex_dREN  in  1  execute-stage instruction is a load
ex_wsel  in  REG_W  execute-stage destination register
mem_dREN  in  1  memory-stage load
mem_dWEN  in  1  memory-stage store
ex_taken  in  1  branch/jump resolved taken in execute
de_halt  in  1  halt opcode in decode
wb_halt  in  1  halt reached writeback
pc_en  out  1  PC register update
fd_en, de_en, em_en, mw_en  out  1 each  latch enable
fd_flush, de_flush, em_flush, mw_flush  out  1 each  latch loads zero (dominates its enable)
halt  out  1  sticky processor halt
stall_cnt  out  CNT_W  cycles with pc_en=0 before HALTED

Behaviour:
- Single clock CLK; reset nRST asynchronous, active-low.
- Registered: state, halt, stall_cnt. All enables/flushes are combinational from state and inputs.
- While nRST=0:
  - state=RUN, halt=0, stall_cnt=0.
  - All enables 0, all flushes 1.
- States: RUN, DMEM_WAIT, DRAIN, HALTED.
- Definitions:
  - dmem_busy = (mem_dREN | mem_dWEN) & ~dhit.
  - lu = ex_dREN & ex_wsel!=0 & (ex_wsel==de_rs | (de_uses_rt & ex_wsel==de_rt)).
- RUN / DRAIN: first matching rule wins.
  1. dmem_busy: all en=0, no flush. Next state is DMEM_WAIT from RUN; DRAIN stays DRAIN.
  2. ex_taken: pc_en=1, fd_flush=1, de_flush=1, em_en=mw_en=1. Branch beats load-use and de_halt, because both are wrong-path.
  3. lu: pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1. Inserts exactly one bubble; the hazard clears naturally the next cycle.
  4. de_halt (RUN only): next state is DRAIN. This cycle: pc_en=0, fd_flush=1, de_en=em_en=mw_en=1.
  5. Otherwise: pc_en=fd_en=ihit, fd_flush=~ihit, de_en=em_en=mw_en=1.
- In DRAIN:
  - pc_en=0 and fd_flush=1 always; rule 5 is replaced by this.
  - wb_halt=1: next state HALTED, halt<=1.
- DMEM_WAIT:
  - All en=0 until dhit.
  - On the dhit cycle: apply the RUN rules 2–5 with dmem_busy treated as 0, then return to RUN.
  - ihit is ignored while waiting: the fetch is retried after release.
- HALTED: all en=0, all flush=0, halt=1, held until reset.
- stall_cnt: increments on every cycle with nRST=1, state≠HALTED and pc_en=0. Saturates at all-ones; does not wrap.
- Simultaneous events:
  - Reset mid-stall or mid-drain returns immediately to RUN with the reset values above.
  - wb_halt outside DRAIN is ignored.
  - ex_wsel=0 never causes a stall.

Decomposition:
- Shared package cpu_types_pkg gains:
  - hazard_state_t enum {RUN, DMEM_WAIT, DRAIN, HALTED}
  - regbits_t (already present) for de_rs, de_rt, ex_wsel
- Interface hazard_controller_if bundles the ports, with modports hc (controller) and tb.
- No sub-module; the saturating counter is an always_ff inside this block.

Test Plan:
- Load-use: ex_dREN=1, ex_wsel=5, de_rs=5, ihit=1 → one cycle of pc_en=0, fd_en=0, de_flush=1, em_en=1. Next cycle, with ex_dREN=0, pc_en=1. stall_cnt=1.
- Branch plus load-use together: ex_taken=1 and lu true → pc_en=1, fd_flush=de_flush=1, no stall; stall_cnt unchanged.
- Data wait: mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 → 3 cycles all en=0 in DMEM_WAIT; release cycle all en=1; state RUN; stall_cnt=3 (release cycle excluded when ihit=1).
- Halt: de_halt=1, then wb_halt=1 three cycles later → fd_flush=1 throughout DRAIN, halt=1 the cycle after wb_halt. It stays 1, with all en=0, for 10 further cycles.
- Fetch miss: ihit=0 for 2 cycles in RUN → pc_en=fd_en=0, fd_flush=1, de_en=1; stall_cnt=2.
- Reset mid-DMEM_WAIT: drop nRST asynchronously → halt=0, stall_cnt=0, all flush=1 immediately; after release, state RUN.
